// File: rtl/mux_n_1_pipe_pkg.sv
// Shared helpers for the parametrised datapath muxes: select-width sizing and
// the flattened-bus convention (input i lives at bits [i*WIDTH +: WIDTH]).
package mux_n_1_pipe_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 mux over a flattened bus; an out-of-range select yields
// zero data with err set.
module mux_n_1
  import mux_n_1_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        y,
  output logic                    err
);

  always_comb begin
    // NOTE: defaults assigned before the loop so every path drives y/err and no latch is inferred.
    y   = '0;
    err = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        y   = d[slice_lo(i, WIDTH) +: WIDTH];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_pipe.sv
// Registered N:1 mux with valid/ready handshake and a one-entry skid buffer,
// so in_ready never depends combinationally on out_ready.
module mux_n_1_pipe
  import mux_n_1_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] mux_y;
  logic             mux_err;
  logic [WIDTH-1:0] sk_data;
  logic             sk_err;
  logic             skid_valid;
  logic             in_ready_q;
  logic             accept;
  logic             drain;

  mux_n_1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .d   (d),
    .sel (sel),
    .y   (mux_y),
    .err (mux_err)
  );

  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q;
  assign drain    = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (drain && skid_valid) begin
        out        <= sk_data;
        out_err    <= sk_err;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (drain && accept) begin
        out       <= mux_y;
        out_err   <= mux_err;
        out_valid <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      if (!drain && accept) begin
        skid_valid <= 1'b1;
        in_ready_q <= 1'b0;
      end
    end
  end

  // NOTE: skid payload has no reset; skid_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (!drain && accept) begin
      sk_data <= mux_y;
      sk_err  <= mux_err;
    end
  end

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Scoreboard bench for mux_n_1_pipe: accepted beats are predicted from the
// select rule and queued; a monitor pops and compares on every output transfer.
module tb_mux_n_1_pipe;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] d;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  logic [WIDTH-1:0] din [NUM_IN];

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;
  beat_t held;
  logic  stalled = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  mux_n_1_pipe #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    d = '0;
    for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = din[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: an in-range select returns that input, anything else is zero with err.
  function automatic beat_t model(input int s);
    beat_t b;
    if (s < NUM_IN) begin
      b.data = din[s];
      b.err  = 1'b0;
    end else begin
      b.data = '0;
      b.err  = 1'b1;
    end
    return b;
  endfunction

  // Predict on acceptance (inputs are stable between edges).
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back(model(int'(sel)));
  end

  // Monitor: compare each transfer and check the stall-hold rule.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out), 32'(held.data));
        check("stall_err", 32'(out_err), 32'(held.err));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h err %0b expected none at %0t", out, out_err, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("sb_data", 32'(out), 32'(exp_b.data));
          check("sb_err", 32'(out_err), 32'(exp_b.err));
          n_out++;
        end
      end
      stalled   = out_valid && !out_ready;
      held.data = out;
      held.err  = out_err;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    sel       = '0;
    out_ready = 1'b1;
    din[0] = 16'hAAAA;
    din[1] = 16'hBBBB;
    din[2] = 16'hCCCC;
    din[3] = 16'hDDDD;
    din[4] = 16'hEEEE;

    // Reset held two cycles with in_valid high.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    check("rst_no_beat", 32'(out_valid), 32'd0);

    // Stream, one beat per cycle, one cycle latency.
    for (int s = 0; s < 4; s++) begin
      sel      = SEL_W'(s);
      in_valid = 1'b1;
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out), 32'(din[s]));
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_idle", 32'(out_valid), 32'd0);

    // Back-pressure: second beat skids, third waits for release.
    sel      = 3'd0;
    in_valid = 1'b1;
    step();
    check("bp_first", 32'(out), 32'hAAAA);
    out_ready = 1'b0;
    sel       = 3'd1;
    step();
    check("bp_hold", 32'(out), 32'hAAAA);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    sel = 3'd2;
    step();
    check("bp_hold2", 32'(out), 32'hAAAA);
    check("bp_in_ready_low2", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_release", 32'(out), 32'hBBBB);
    check("bp_in_ready_up", 32'(in_ready), 32'd1);
    step();
    check("bp_third", 32'(out), 32'hCCCC);
    in_valid = 1'b0;
    step();
    check("bp_idle", 32'(out_valid), 32'd0);

    // Out-of-range selects and the last legal index.
    sel      = 3'd5;
    in_valid = 1'b1;
    step();
    check("oor_data", 32'(out), 32'd0);
    check("oor_err", 32'(out_err), 32'd1);
    sel = 3'd4;
    step();
    check("last_data", 32'(out), 32'hEEEE);
    check("last_err", 32'(out_err), 32'd0);
    sel = 3'd7;
    step();
    check("oor_max_err", 32'(out_err), 32'd1);
    in_valid = 1'b0;
    step();

    // Mid-stall reset discards OR and SK.
    out_ready = 1'b0;
    sel       = 3'd0;
    in_valid  = 1'b1;
    step();
    sel = 3'd1;
    step();
    check("mid_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_ghost", 32'(out_valid), 32'd0);
    end

    // Random traffic against the queue model.
    for (int c = 0; c < 800; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sel       = SEL_W'($urandom_range(0, 7));
      for (int i = 0; i < NUM_IN; i++) din[i] = WIDTH'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
